// File: rtl/booth4_pkg.sv
// Shared Booth radix-4 definitions: operation encoding, triplet decode,
// and width helpers used by the serial and parallel partial-product generators.
package booth4_pkg;

    // Operand width used when a generator is instantiated without override.
    localparam int DEFAULT_WIDTH = 16;

    // Multiple of the multiplicand selected by one Booth triplet.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG2 = 3'd3,
        NEG1 = 3'd4
    } booth_op_e;

    // Serializer control states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ser_state_e;

    // Number of partial-product rows for a given operand width.
    function automatic int calc_npp(input int width);
        return width / 2;
    endfunction

    // Partial-product row width: one guard bit so that 2x is always exact.
    function automatic int calc_ppw(input int width);
        return width + 1;
    endfunction

    // Map {y[2i+1], y[2i], y[2i-1]} to the selected multiple.
    // 111 maps to ZERO (not a negated zero) so no spurious +1 is injected.
    function automatic booth_op_e booth_decode(input logic [2:0] trip);
        booth_op_e op;
        case (trip)
            3'b000:  op = ZERO;
            3'b001:  op = POS1;
            3'b010:  op = POS1;
            3'b011:  op = POS2;
            3'b100:  op = NEG2;
            3'b101:  op = NEG1;
            3'b110:  op = NEG1;
            3'b111:  op = ZERO;
            default: op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth4_enc.sv
// Combinational Booth radix-4 row encoder: selects 0/x/2x from a triplet and
// returns the one's-complement row plus the neg bit the compressor tree adds.
module booth4_enc
    import booth4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]     triplet,
    input  logic [WIDTH:0] x_sext,
    output logic [WIDTH:0] pp_data,
    output logic           pp_neg
);

    booth_op_e        op_s;
    logic [WIDTH:0]   x2_s;
    logic [WIDTH:0]   mag_s;

    // 2x inside the guard-bit width is exact for every signed WIDTH-bit x.
    assign x2_s = {x_sext[WIDTH-1:0], 1'b0};

    // Decode the triplet into an operation.
    always_comb begin
        op_s = booth_decode(triplet);
    end

    // Select the magnitude multiple and invert it for negative rows.
    always_comb begin
        mag_s  = '0;
        pp_neg = 1'b0;
        case (op_s)
            ZERO: begin
                mag_s  = '0;
                pp_neg = 1'b0;
            end
            POS1: begin
                mag_s  = x_sext;
                pp_neg = 1'b0;
            end
            POS2: begin
                mag_s  = x2_s;
                pp_neg = 1'b0;
            end
            NEG2: begin
                mag_s  = x2_s;
                pp_neg = 1'b1;
            end
            NEG1: begin
                mag_s  = x_sext;
                pp_neg = 1'b1;
            end
            default: begin
                mag_s  = '0;
                pp_neg = 1'b0;
            end
        endcase
        if (pp_neg) begin
            pp_data = ~mag_s;
        end else begin
            pp_data = mag_s;
        end
    end

endmodule

// File: rtl/booth4_pp_serializer.sv
// Booth radix-4 partial-product serializer: accepts one signed operand pair
// and streams NPP rows (one's-complement data + neg bit) to the compressor tree.
module booth4_pp_serializer
    import booth4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     mcand,
    input  logic [WIDTH-1:0]                     mplier,
    output logic                                 pp_valid,
    input  logic                                 pp_ready,
    output logic [WIDTH:0]                       pp_data,
    output logic                                 pp_neg,
    output logic [$clog2(calc_npp(WIDTH))-1:0]   pp_idx,
    output logic                                 pp_last
);

    localparam int NPP  = calc_npp(WIDTH);
    localparam int PPW  = calc_ppw(WIDTH);
    localparam int IDXW = $clog2(NPP);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPP - 1);

    // Reject illegal widths at elaboration time.
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("booth4_pp_serializer: WIDTH must be even and at least 4");
    end

    ser_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               in_ready_q, in_ready_d;
    logic               pp_valid_q, pp_valid_d;
    logic [PPW-1:0]     pp_data_q, pp_data_d;
    logic               pp_neg_q, pp_neg_d;
    logic [IDXW-1:0]    pp_idx_q, pp_idx_d;
    logic               pp_last_q, pp_last_d;

    logic [WIDTH-1:0]   enc_x_raw_s;
    logic [WIDTH-1:0]   enc_y_s;
    logic [IDXW-1:0]    enc_row_s;
    logic [IDXW-1:0]    next_idx_s;
    logic [WIDTH:0]     enc_y_ext_s;
    logic [2:0]         enc_trip_s;
    logic [PPW-1:0]     enc_x_sext_s;
    logic [PPW-1:0]     enc_data_s;
    logic               enc_neg_s;

    // Choose encoder operands: live ports for row 0 at acceptance, otherwise
    // the latched operands for the row after the one currently presented.
    always_comb begin
        next_idx_s = pp_idx_q + IDXW'(1'b1);
        if (state_q == ST_IDLE) begin
            enc_x_raw_s = mcand;
            enc_y_s     = mplier;
            enc_row_s   = '0;
        end else begin
            enc_x_raw_s = mcand_q;
            enc_y_s     = mplier_q;
            enc_row_s   = next_idx_s;
        end
        enc_y_ext_s  = {enc_y_s, 1'b0};
        enc_x_sext_s = {enc_x_raw_s[WIDTH-1], enc_x_raw_s};
    end

    // Extract the Booth triplet for the selected row (y[-1] is the appended 0).
    always_comb begin
        enc_trip_s = 3'b000;
        for (int i = 0; i < NPP; i++) begin
            enc_trip_s = (enc_row_s == IDXW'(i)) ? enc_y_ext_s[2*i +: 3] : enc_trip_s;
        end
    end

    booth4_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .triplet (enc_trip_s),
        .x_sext  (enc_x_sext_s),
        .pp_data (enc_data_s),
        .pp_neg  (enc_neg_s)
    );

    // Next-state and next-output logic for the accept/emit sequence.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        in_ready_d = in_ready_q;
        pp_valid_d = pp_valid_q;
        pp_data_d  = pp_data_q;
        pp_neg_d   = pp_neg_q;
        pp_idx_d   = pp_idx_q;
        pp_last_d  = pp_last_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    mcand_d    = mcand;
                    mplier_d   = mplier;
                    pp_data_d  = enc_data_s;
                    pp_neg_d   = enc_neg_s;
                    pp_idx_d   = '0;
                    pp_last_d  = 1'b0;
                    pp_valid_d = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = ST_EMIT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EMIT: begin
                in_ready_d = 1'b0;
                if (pp_valid_q && pp_ready) begin
                    if (pp_last_q) begin
                        // Final row consumed: drop valid and reopen the input.
                        pp_valid_d = 1'b0;
                        in_ready_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Present the next row on the same edge, no bubble.
                        pp_data_d  = enc_data_s;
                        pp_neg_d   = enc_neg_s;
                        pp_idx_d   = next_idx_s;
                        pp_last_d  = (next_idx_s == LAST_IDX);
                        pp_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                pp_valid_d = 1'b0;
            end
        endcase
    end

    // State, operand and output registers with asynchronous reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            in_ready_q <= 1'b1;
            pp_valid_q <= 1'b0;
            pp_data_q  <= '0;
            pp_neg_q   <= 1'b0;
            pp_idx_q   <= '0;
            pp_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            in_ready_q <= in_ready_d;
            pp_valid_q <= pp_valid_d;
            pp_data_q  <= pp_data_d;
            pp_neg_q   <= pp_neg_d;
            pp_idx_q   <= pp_idx_d;
            pp_last_q  <= pp_last_d;
        end
    end

    assign in_ready = in_ready_q;
    assign pp_valid = pp_valid_q;
    assign pp_data  = pp_data_q;
    assign pp_neg   = pp_neg_q;
    assign pp_idx   = pp_idx_q;
    assign pp_last  = pp_last_q;

endmodule

// File: tb/tb_booth4_pp_serializer.sv
// Self-checking bench for booth4_pp_serializer (WIDTH=16): expected rows are
// pushed to a scoreboard queue at stimulus time and popped as rows appear.
module tb_booth4_pp_serializer;

    localparam int W   = 16;
    localparam int NPP = 8;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic          pp_valid;
    logic          pp_ready;
    logic [W:0]    pp_data;
    logic          pp_neg;
    logic [2:0]    pp_idx;
    logic          pp_last;

    typedef struct {
        logic [W:0] d;
        logic       n;
        logic [2:0] idx;
        logic       last;
    } row_t;

    row_t sb[$];
    int   n_asserts;
    int   n_fails;

    booth4_pp_serializer #(
        .WIDTH (W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .pp_valid  (pp_valid),
        .pp_ready  (pp_ready),
        .pp_data   (pp_data),
        .pp_neg    (pp_neg),
        .pp_idx    (pp_idx),
        .pp_last   (pp_last)
    );

    // Free-running clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Reference row: arithmetic multiple of x chosen by the Booth digit value.
    function automatic void exp_row(input logic [W-1:0] x, input logic [W-1:0] y, input int i,
                                    output logic [W:0] d, output logic n);
        logic [W:0] yx;
        logic [2:0] trip;
        int         v;
        int         mag;
        logic [W:0] p;
        yx   = {y, 1'b0};
        trip = yx[2*i +: 3];
        case (trip)
            3'b000, 3'b111: v = 0;
            3'b001, 3'b010: v = 1;
            3'b011:         v = 2;
            3'b100:         v = -2;
            default:        v = -1;
        endcase
        mag = (v < 0) ? -v : v;
        p   = 17'(mag * int'($signed(x)));
        d   = (v < 0) ? ~p : p;
        n   = (v < 0);
    endfunction

    // One operation: optional 3-cycle stall on stall_row, optional reset on abort_row.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int stall_row, input int abort_row);
        row_t              r;
        logic [31:0]       acc;
        logic [31:0]       term;
        logic signed [31:0] prod;
        int                guard;
        for (int i = 0; i < NPP; i++) begin
            exp_row(x, y, i, r.d, r.n);
            r.idx  = 3'(i);
            r.last = (i == NPP - 1);
            sb.push_back(r);
        end
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge sys_clk);
            guard++;
        end
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        mcand    = x;
        mplier   = y;
        pp_ready = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        mcand    = 16'($urandom);
        mplier   = 16'($urandom);
        acc      = 32'd0;
        while (sb.size() > 0) begin
            guard = 0;
            while (!pp_valid && guard < 20) begin
                @(negedge sys_clk);
                guard++;
            end
            chk("pp_valid", {63'd0, pp_valid}, 64'd1);
            r = sb.pop_front();
            chk("pp_data", {47'd0, pp_data}, {47'd0, r.d});
            chk("pp_neg",  {63'd0, pp_neg},  {63'd0, r.n});
            chk("pp_idx",  {61'd0, pp_idx},  {61'd0, r.idx});
            chk("pp_last", {63'd0, pp_last}, {63'd0, r.last});
            chk("in_ready_emit", {63'd0, in_ready}, 64'd0);
            term = {{15{pp_data[W]}}, pp_data} + {31'd0, pp_neg};
            acc  = acc + (term << (2 * int'(r.idx)));
            if (int'(r.idx) == abort_row) begin
                #2 sys_rst_n = 1'b0;
                #1;
                chk("rst_pp_valid", {63'd0, pp_valid}, 64'd0);
                chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
                chk("rst_pp_last",  {63'd0, pp_last},  64'd0);
                chk("rst_pp_data",  {47'd0, pp_data},  64'd0);
                sb.delete();
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
                @(negedge sys_clk);
                chk("post_rst_valid", {63'd0, pp_valid}, 64'd0);
                return;
            end
            if (int'(r.idx) == stall_row) begin
                pp_ready = 1'b0;
                in_valid = 1'b1;
                mcand    = ~x;
                mplier   = ~y;
                repeat (3) begin
                    @(negedge sys_clk);
                    chk("stall_valid", {63'd0, pp_valid}, 64'd1);
                    chk("stall_data",  {47'd0, pp_data},  {47'd0, r.d});
                    chk("stall_idx",   {61'd0, pp_idx},   {61'd0, r.idx});
                    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                end
                in_valid = 1'b0;
                pp_ready = 1'b1;
            end
            @(negedge sys_clk);
        end
        chk("done_pp_valid", {63'd0, pp_valid}, 64'd0);
        chk("done_in_ready", {63'd0, in_ready}, 64'd1);
        prod = $signed(x) * $signed(y);
        chk("invariant", {32'd0, acc}, {32'd0, prod});
    endtask

    // Directed sequence followed by random operand pairs.
    initial begin
        n_asserts = 0;
        n_fails   = 0;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        mcand     = 16'h0000;
        mplier    = 16'h0000;
        pp_ready  = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_pp_valid", {63'd0, pp_valid}, 64'd0);
        chk("reset_pp_data",  {47'd0, pp_data},  64'd0);
        chk("reset_pp_neg",   {63'd0, pp_neg},   64'd0);
        chk("reset_pp_idx",   {61'd0, pp_idx},   64'd0);
        chk("reset_pp_last",  {63'd0, pp_last},  64'd0);
        sys_rst_n = 1'b1;
        pp_ready  = 1'b1;
        @(negedge sys_clk);
        chk("idle_ready_no_effect", {63'd0, pp_valid}, 64'd0);

        run_op(16'h0003, 16'h0001, -1, -1);
        run_op(16'h0005, 16'hFFFF, -1, -1);
        run_op(16'h7FFF, 16'h0002, -1, -1);
        run_op(16'h8000, 16'h4000, -1, -1);
        run_op(16'h8000, 16'h8000, -1, -1);
        run_op(16'h1234, 16'h5678, 2, -1);
        run_op(16'hBEEF, 16'hA5A5, -1, 4);
        run_op(16'h0003, 16'h0001, -1, -1);

        for (int k = 0; k < 300; k++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
